// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, instruction
// classes, step encoding and the registered control word.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RTYPE, IMM, LD, LDI, ST, BR, JR, MFX, MULDIV, NOP, HALT, ILLEGAL
    } instr_cls_e;

    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_T8 = 4'd8, S_T9 = 4'd9, S_T10 = 4'd10, S_T11 = 4'd11,
        S_HALT = 4'd15
    } state_e;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       ba_out;
        logic       con_in;
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_read;
        logic       mdr_out;
        logic       ram_write;
        logic       ir_in;
        logic       y_in;
        logic       c_out;
        logic       z_in;
        logic       z_lo_sel;
        logic       z_lo_out;
        logic       z_hi_sel;
        logic       z_hi_out;
        logic       hi_in;
        logic       lo_in;
        logic       hi_out;
        logic       lo_out;
        logic       illegal;
        logic [4:0] alu;
    } ctrl_t;

    // Final step of each class; classes that end at T4 include nop and illegal.
    function automatic state_e last_step(input instr_cls_e cls);
        case (cls)
            RTYPE, IMM, LDI: last_step = S_T6;
            LD:              last_step = S_T9;
            ST:              last_step = S_T8;
            BR, MULDIV:      last_step = S_T7;
            default:         last_step = S_T4;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: IR[31:27] to instruction class and ALU operation.
// CTRL_MULDIV_EN enables decoding of mul/div; otherwise they are illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]  opcode,
    output instr_cls_e  cls,
    output logic [4:0]  alu_op
);

    always_comb begin
        cls    = ILLEGAL;
        alu_op = 5'd0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
                cls    = RTYPE;
                alu_op = opcode;
            end
            OP_ADDI: begin cls = IMM; alu_op = OP_ADD; end
            OP_ANDI: begin cls = IMM; alu_op = OP_AND; end
            OP_ORI:  begin cls = IMM; alu_op = OP_OR;  end
            // Address calculations all use the adder.
            OP_LD:   begin cls = LD;  alu_op = OP_ADD; end
            OP_LDI:  begin cls = LDI; alu_op = OP_ADD; end
            OP_ST:   begin cls = ST;  alu_op = OP_ADD; end
            OP_BR:   begin cls = BR;  alu_op = OP_ADD; end
            OP_JR:   cls = JR;
            OP_MFHI, OP_MFLO: cls = MFX;
            OP_NOP:  cls = NOP;
            OP_HALT: cls = HALT;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV: begin
                cls    = MULDIV;
                alu_op = opcode;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control unit: fetch, decode, and registered datapath controls.
// CTRL_MULDIV_EN enables mul/div sequencing (HI/LO writes and Z high readout).
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_ff_out,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAOut,
    output logic        CON_ff_in,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRread,
    output logic        MDRout,
    output logic        RAM_write,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        Zin,
    output logic        ZLowSelect,
    output logic        ZLOout,
    output logic        ZHighSelect,
    output logic        ZHIout,
    output logic        HIin,
    output logic        Loin,
    output logic        HIout,
    output logic        Loout,
    output logic [4:0]  ALU_opcode,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  step
);

    localparam int WW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_e      state_q, state_d;
    instr_cls_e  cls_q, cls_d, dec_cls;
    logic [4:0]  op_q, op_d, alu_q, alu_d, dec_alu;
    logic [WW-1:0] wait_q, wait_d;
    logic        active_q, active_d;
    ctrl_t       ctl_q, ctl_d;
    logic        run_q, run_d;
    logic [3:0]  step_q, step_d;
    logic        in_wait;
    logic        unused_ir;

    assign unused_ir = ^IR[26:0];

    ctrl_decode u_decode (
        .opcode (IR[31:27]),
        .cls    (dec_cls),
        .alu_op (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_T0;
            cls_q    <= NOP;
            op_q     <= 5'd0;
            alu_q    <= 5'd0;
            wait_q   <= '0;
            active_q <= 1'b0;
            ctl_q    <= '0;
            run_q    <= 1'b0;
            step_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            op_q     <= op_d;
            alu_q    <= alu_d;
            wait_q   <= wait_d;
            active_q <= active_d;
            ctl_q    <= ctl_d;
            run_q    <= run_d;
            step_q   <= step_d;
        end
    end

    // RAM wait steps: T1 of every fetch and T7 of ld, each stretched to RAM_LAT cycles.
    assign in_wait = (state_q == S_T1) || (state_q == S_T7 && cls_q == LD);

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        active_d = 1'b1;
        cls_d    = cls_q;
        op_d     = op_q;
        alu_d    = alu_q;
        if (state_q == S_T3) begin
            cls_d = dec_cls;
            op_d  = IR[31:27];
            alu_d = dec_alu;
        end
        if (!active_q)
            state_d = S_T0;
        else if (state_q == S_HALT)
            state_d = S_HALT;
        else if (in_wait && wait_q != WW'(RAM_LAT - 1)) begin
            state_d = state_q;
            wait_d  = wait_q + 1'b1;
        end else if (state_q == S_T3 && dec_cls == HALT)
            state_d = S_HALT;
        else if (state_q >= S_T4 && state_q == last_step(cls_q))
            state_d = stop ? S_HALT : S_T0;
        else
            state_d = state_e'(state_q + 4'd1);
    end

    // Controls are decoded from the step being entered, so they register in line with it.
    always_comb begin
        ctl_d = '0;
        case (state_d)
            S_T0: begin ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1; ctl_d.inc_pc = 1'b1; end
            S_T2: begin ctl_d.mdr_read = 1'b1; ctl_d.mdr_in = 1'b1; end
            S_T3: begin ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1; end
            S_T4: case (cls_d)
                RTYPE, IMM: begin ctl_d.grb = 1'b1; ctl_d.rout = 1'b1; ctl_d.y_in = 1'b1; end
                LD, LDI, ST: begin ctl_d.grb = 1'b1; ctl_d.ba_out = 1'b1; ctl_d.y_in = 1'b1; end
                BR: begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.con_in = 1'b1; end
                JR: begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.pc_in = 1'b1; end
                MFX: begin
                    ctl_d.hi_out = (op_d == OP_MFHI);
                    ctl_d.lo_out = (op_d != OP_MFHI);
                    ctl_d.gra    = 1'b1;
                    ctl_d.rin    = 1'b1;
                end
                MULDIV: begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.y_in = 1'b1; end
                ILLEGAL: ctl_d.illegal = 1'b1;
                default: ;
            endcase
            S_T5: case (cls_d)
                RTYPE: begin ctl_d.grc = 1'b1; ctl_d.rout = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu = alu_d; end
                IMM, LD, LDI, ST: begin ctl_d.c_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu = alu_d; end
                BR: begin ctl_d.pc_out = 1'b1; ctl_d.y_in = 1'b1; end
                MULDIV: begin ctl_d.grb = 1'b1; ctl_d.rout = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu = alu_d; end
                default: ;
            endcase
            S_T6: case (cls_d)
                RTYPE, IMM, LDI: begin
                    ctl_d.z_lo_sel = 1'b1; ctl_d.z_lo_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.rin = 1'b1;
                end
                LD, ST: begin ctl_d.z_lo_sel = 1'b1; ctl_d.z_lo_out = 1'b1; ctl_d.mar_in = 1'b1; end
                BR: begin ctl_d.c_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu = alu_d; end
                MULDIV: begin ctl_d.z_lo_sel = 1'b1; ctl_d.z_lo_out = 1'b1; ctl_d.lo_in = 1'b1; end
                default: ;
            endcase
            S_T7: case (cls_d)
                ST: begin ctl_d.gra = 1'b1; ctl_d.rout = 1'b1; ctl_d.mdr_in = 1'b1; end
                BR: begin ctl_d.z_lo_sel = 1'b1; ctl_d.z_lo_out = 1'b1; ctl_d.pc_in = CON_ff_out; end
                MULDIV: begin ctl_d.z_hi_sel = 1'b1; ctl_d.z_hi_out = 1'b1; ctl_d.hi_in = 1'b1; end
                default: ;
            endcase
            S_T8: case (cls_d)
                LD: begin ctl_d.mdr_read = 1'b1; ctl_d.mdr_in = 1'b1; end
                ST: ctl_d.ram_write = 1'b1;
                default: ;
            endcase
            S_T9: if (cls_d == LD) begin
                ctl_d.mdr_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.rin = 1'b1;
            end
            default: ;
        endcase
`ifndef CTRL_MULDIV_EN
        ctl_d.hi_in    = 1'b0;
        ctl_d.lo_in    = 1'b0;
        ctl_d.z_hi_sel = 1'b0;
        ctl_d.z_hi_out = 1'b0;
`endif
        run_d  = (state_d != S_HALT);
        step_d = (state_d == S_HALT) ? 4'd0 : 4'(state_d);
    end

    assign Gra         = ctl_q.gra;
    assign Grb         = ctl_q.grb;
    assign Grc         = ctl_q.grc;
    assign Rin         = ctl_q.rin;
    assign Rout        = ctl_q.rout;
    assign BAOut       = ctl_q.ba_out;
    assign CON_ff_in   = ctl_q.con_in;
    assign PCout       = ctl_q.pc_out;
    assign PCin        = ctl_q.pc_in;
    assign IncPC       = ctl_q.inc_pc;
    assign MARin       = ctl_q.mar_in;
    assign MDRin       = ctl_q.mdr_in;
    assign MDRread     = ctl_q.mdr_read;
    assign MDRout      = ctl_q.mdr_out;
    assign RAM_write   = ctl_q.ram_write;
    assign IRin        = ctl_q.ir_in;
    assign Yin         = ctl_q.y_in;
    assign Cout        = ctl_q.c_out;
    assign Zin         = ctl_q.z_in;
    assign ZLowSelect  = ctl_q.z_lo_sel;
    assign ZLOout      = ctl_q.z_lo_out;
    assign ZHighSelect = ctl_q.z_hi_sel;
    assign ZHIout      = ctl_q.z_hi_out;
    assign HIin        = ctl_q.hi_in;
    assign Loin        = ctl_q.lo_in;
    assign HIout       = ctl_q.hi_out;
    assign Loout       = ctl_q.lo_out;
    assign illegal     = ctl_q.illegal;
    assign ALU_opcode  = ctl_q.alu;
    assign run         = run_q;
    assign step        = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction step lists from a
// reference model are queued by the driver and compared cycle by cycle by a monitor.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        CON_ff_out, stop;
    logic Gra, Grb, Grc, Rin, Rout, BAOut, CON_ff_in;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, RAM_write, IRin, Yin, Cout;
    logic Zin, ZLowSelect, ZLOout, ZHighSelect, ZHIout, HIin, Loin, HIout, Loout;
    logic [4:0] ALU_opcode;
    logic run, illegal;
    logic [3:0] step;

    always #5 clk = ~clk;

    control_sequencer #(.RAM_LAT(1)) dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_ff_out(CON_ff_out), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAOut(BAOut),
        .CON_ff_in(CON_ff_in), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout),
        .RAM_write(RAM_write), .IRin(IRin), .Yin(Yin), .Cout(Cout), .Zin(Zin),
        .ZLowSelect(ZLowSelect), .ZLOout(ZLOout), .ZHighSelect(ZHighSelect),
        .ZHIout(ZHIout), .HIin(HIin), .Loin(Loin), .HIout(HIout), .Loout(Loout),
        .ALU_opcode(ALU_opcode), .run(run), .illegal(illegal), .step(step)
    );

    localparam logic [27:0] M_GRA = 28'd1 << 0,  M_GRB = 28'd1 << 1,  M_GRC = 28'd1 << 2;
    localparam logic [27:0] M_RIN = 28'd1 << 3,  M_ROUT = 28'd1 << 4, M_BAOUT = 28'd1 << 5;
    localparam logic [27:0] M_CONIN = 28'd1 << 6, M_PCOUT = 28'd1 << 7, M_PCIN = 28'd1 << 8;
    localparam logic [27:0] M_INCPC = 28'd1 << 9, M_MARIN = 28'd1 << 10, M_MDRIN = 28'd1 << 11;
    localparam logic [27:0] M_MDRRD = 28'd1 << 12, M_MDROUT = 28'd1 << 13, M_RAMWR = 28'd1 << 14;
    localparam logic [27:0] M_IRIN = 28'd1 << 15, M_YIN = 28'd1 << 16, M_COUT = 28'd1 << 17;
    localparam logic [27:0] M_ZIN = 28'd1 << 18, M_ZLSEL = 28'd1 << 19, M_ZLOOUT = 28'd1 << 20;
    localparam logic [27:0] M_ZHSEL = 28'd1 << 21, M_ZHIOUT = 28'd1 << 22, M_HIIN = 28'd1 << 23;
    localparam logic [27:0] M_LOIN = 28'd1 << 24, M_HIOUT = 28'd1 << 25, M_LOOUT = 28'd1 << 26;
    localparam logic [27:0] M_ILL = 28'd1 << 27;
    localparam logic [27:0] M_ZL  = M_ZLSEL | M_ZLOOUT;
    localparam logic [27:0] M_BUS = M_PCOUT | M_MDROUT | M_ROUT | M_BAOUT | M_COUT |
                                    M_ZLOOUT | M_ZHIOUT | M_HIOUT | M_LOOUT;

    logic [27:0] act;
    assign act = {illegal, Loout, HIout, Loin, HIin, ZHIout, ZHighSelect, ZLOout, ZLowSelect,
                  Zin, Cout, Yin, IRin, RAM_write, MDRout, MDRread, MDRin, MARin, IncPC,
                  PCin, PCout, CON_ff_in, BAOut, Rout, Rin, Grc, Grb, Gra};

    typedef struct {
        logic [27:0] ctl;
        logic [4:0]  alu;
        logic [3:0]  step;
        logic        run;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   seq_step;

    function automatic void push(input logic [27:0] c, input logic [4:0] a);
        exp_t e;
        e.ctl = c; e.alu = a; e.step = 4'(seq_step); e.run = 1'b1;
        exp_q.push_back(e);
        seq_step++;
    endfunction

    function automatic void push_idle();
        exp_t e;
        e.ctl = '0; e.alu = '0; e.step = '0; e.run = 1'b0;
        exp_q.push_back(e);
    endfunction

    // Reference: one expected control word per cycle of the instruction.
    task automatic model(input logic [31:0] ir, input logic con, output int n, output bit halts);
        logic [4:0] op;
        int start;
        start = exp_q.size();
        seq_step = 0;
        halts = 1'b0;
        op = ir[31:27];
        push(M_PCOUT | M_MARIN | M_INCPC, 5'd0);
        push(28'd0, 5'd0);
        push(M_MDRRD | M_MDRIN, 5'd0);
        push(M_MDROUT | M_IRIN, 5'd0);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                push(M_GRB | M_ROUT | M_YIN, 5'd0);
                push(M_GRC | M_ROUT | M_ZIN, op);
                push(M_ZL | M_GRA | M_RIN, 5'd0);
            end
            5'd12, 5'd13, 5'd14: begin
                push(M_GRB | M_ROUT | M_YIN, 5'd0);
                push(M_COUT | M_ZIN, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6);
                push(M_ZL | M_GRA | M_RIN, 5'd0);
            end
            5'd0, 5'd1, 5'd2: begin
                push(M_GRB | M_BAOUT | M_YIN, 5'd0);
                push(M_COUT | M_ZIN, 5'd3);
                if (op == 5'd1) push(M_ZL | M_GRA | M_RIN, 5'd0);
                else push(M_ZL | M_MARIN, 5'd0);
                if (op == 5'd0) begin
                    push(28'd0, 5'd0);
                    push(M_MDRRD | M_MDRIN, 5'd0);
                    push(M_MDROUT | M_GRA | M_RIN, 5'd0);
                end
                if (op == 5'd2) begin
                    push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
                    push(M_RAMWR, 5'd0);
                end
            end
            5'd18: begin
                push(M_GRA | M_ROUT | M_CONIN, 5'd0);
                push(M_PCOUT | M_YIN, 5'd0);
                push(M_COUT | M_ZIN, 5'd3);
                push(M_ZL | (con ? M_PCIN : 28'd0), 5'd0);
            end
            5'd20: push(M_GRA | M_ROUT | M_PCIN, 5'd0);
            5'd24: push(M_HIOUT | M_GRA | M_RIN, 5'd0);
            5'd25: push(M_LOOUT | M_GRA | M_RIN, 5'd0);
            5'd26: push(28'd0, 5'd0);
            5'd27: halts = 1'b1;
`ifdef CTRL_MULDIV_EN
            5'd15, 5'd16: begin
                push(M_GRA | M_ROUT | M_YIN, 5'd0);
                push(M_GRB | M_ROUT | M_ZIN, op);
                push(M_ZL | M_LOIN, 5'd0);
                push(M_ZHSEL | M_ZHIOUT | M_HIIN, 5'd0);
            end
`endif
            default: push(M_ILL, 5'd0);
        endcase
        n = exp_q.size() - start;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Runs one instruction; stop rises before cycle stop_at; only the first keep cycles are run.
    task automatic issue(input logic [31:0] ir, input logic con, input int stop_at, input int keep);
        int n;
        bit h;
        IR = ir;
        CON_ff_out = con;
        model(ir, con, n, h);
        if (keep < n) begin
            repeat (n - keep) void'(exp_q.pop_back());
            n = keep;
        end
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) stop = 1'b1;
            tick();
        end
    endtask

    task automatic reset_pulse();
        clr = 1'b0;
        push_idle();
        tick();
        clr = 1'b1;
        stop = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            push_idle();
            tick();
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        mk = {op, ra, rb, rc, 15'd0};
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({act, ALU_opcode, step, run} !== {e.ctl, e.alu, e.step, e.run}) begin
                    failures++;
                    $display("FAIL step_ctrl t=%0t got ctl=%h alu=%0d step=%0d run=%b, want ctl=%h alu=%0d step=%0d run=%b",
                             $time, act, ALU_opcode, step, run, e.ctl, e.alu, e.step, e.run);
                end
                checks++;
                if ($countones(act & M_BUS) > 1) begin
                    failures++;
                    $display("FAIL bus_drivers t=%0t got %0d drivers (ctl=%h), want at most 1",
                             $time, $countones(act & M_BUS), act);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [4:0] op;
        clr = 1'b0; IR = '0; CON_ff_out = 1'b0; stop = 1'b0; seq_step = 0;
        repeat (2) @(posedge clk);
        tick();
        push_idle();
        tick();
        clr = 1'b1;

        issue(mk(5'b00011, 4'd1, 4'd2, 4'd3), 1'b0, -1, 99);   // add
        issue(mk(5'b00000, 4'd4, 4'd0, 4'd0), 1'b0, -1, 99);   // ld
        issue(mk(5'b10010, 4'd5, 4'd0, 4'd0), 1'b0, -1, 99);   // br not taken
        issue(mk(5'b10010, 4'd5, 4'd0, 4'd0), 1'b1, -1, 99);   // br taken
        issue(mk(5'b11111, 4'd0, 4'd0, 4'd0), 1'b0, -1, 99);   // illegal
        issue(mk(5'b01111, 4'd2, 4'd3, 4'd0), 1'b0, -1, 99);   // mul
        issue(mk(5'b11010, 4'd0, 4'd0, 4'd0), 1'b0, -1, 99);   // nop

        // stop raised mid-st takes effect only after the RAM_write step
        issue(mk(5'b00010, 4'd6, 4'd7, 4'd0), 1'b0, 2, 99);
        idle_cycles(3);
        reset_pulse();

        // reset during st T7 suppresses the RAM_write step
        issue(mk(5'b00010, 4'd6, 4'd7, 4'd0), 1'b0, -1, 8);
        reset_pulse();

        // halt instruction, then recovery via clr
        issue(mk(5'b11011, 4'd0, 4'd0, 4'd0), 1'b0, -1, 99);
        idle_cycles(2);
        reset_pulse();

        for (int k = 0; k < 80; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            if ($urandom_range(0, 7) == 0) begin
                issue(mk(op, 4'($urandom), 4'($urandom), 4'($urandom)), 1'($urandom),
                      -1, $urandom_range(1, 12));
                reset_pulse();
            end else begin
                issue(mk(op, 4'($urandom), 4'($urandom), 4'($urandom)), 1'($urandom), -1, 99);
            end
        end

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
